pe_dot_seq: RTL and testbench
=============================

Name: pe_dot_seq

Overview:
Sequencer for the Q8.8 processing-element MAC datapath. It accepts a configured vector length and streams A/B operand pairs through a registered multiply stage into a wide full-precision accumulator. At the end it applies round-half-up and int16 saturation once and returns a single Q8.8 dot-product result. It sits between the NPU operand feeder (valid/ready) and the PE result collector (valid/ready).

Parameters:
DATA_W, 16, operand/result width (signed Q8.8)
FRAC_W, 8, fractional bits of operands and result
LEN_W, 8, width of vector-length field (max 2^LEN_W-1 pairs)
ACC_W, 40, signed accumulator width (Q24.16); must satisfy ACC_W >= 2*DATA_W+LEN_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begin a dot product, sampled only in IDLE
len  in  LEN_W  number of operand pairs, captured with start
busy  out  1  high in any state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can take a pair
a_in  in  DATA_W  operand A, signed Q8.8
b_in  in  DATA_W  operand B, signed Q8.8
out_valid  out  1  result valid
out_ready  in  1  collector accepts result
result  out  DATA_W  rounded, saturated Q8.8 dot product
sat_flag  out  1  result was clamped; valid with out_valid

Behaviour:
- Reset: state=IDLE; busy=0, in_ready=0, out_valid=0, result=0, sat_flag=0; accumulator, product register and counter cleared. Reset wins over every other input, including mid-RUN and while out_valid is held.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 captures len, clears the accumulator and counter. If len!=0, go to RUN. If len==0, go to DONE with result=0 and sat_flag=0.
- RUN: in_ready=1. A handshake (in_valid&&in_ready) registers prod = a_in*b_in (signed 2*DATA_W, Q16.16), sets prod_v=1 and increments the counter. Idle cycles (in_valid=0) are allowed and do not advance the counter.
- Accumulate stage: every cycle with prod_v=1, acc <= acc + sign-extended prod. prod_v clears on the next cycle with no handshake.
- When the handshake for pair number len occurs, in_ready drops the following cycle and the state moves to DRAIN.
- DRAIN: one cycle so the last product is accumulated. Then go to DONE, registering result and sat_flag.
- Rounding and saturation:
  - r = (acc + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift (round half toward +inf).
  - If r > 32767: result=0x7FFF, sat_flag=1.
  - If r < -32768: result=0x8000, sat_flag=1.
  - Otherwise result=r[DATA_W-1:0], sat_flag=0.
  - No intermediate rounding or saturation is ever applied.
- DONE: out_valid=1. result and sat_flag stay stable until out_valid&&out_ready, then go to IDLE. out_valid falls the cycle after the handshake.
- Latency: out_valid rises 2 cycles after the clock edge of the last input handshake (edge E: product registered; E+1: accumulated; E+2: result registered).
- start is ignored when the state is not IDLE. There is no abort; only rst aborts.
- start and the out handshake in the same cycle: the out handshake completes and start is ignored (state is DONE, not IDLE).
- Counter wrap cannot occur: the counter compares against the captured len and stops.
- Accumulator overflow is impossible for the ACC_W constraint above. A simulation assertion checks the parameter relation.

Decomposition:
- Package pe_npu_pkg holds:
  - q8_8_t (signed [15:0]), q16_16_t (signed [31:0]);
  - Q_FRAC=8, Q_MAX=16'sh7FFF, Q_MIN=16'sh8000;
  - the state enum seq_state_e {IDLE, RUN, DRAIN, DONE}.
- One combinational sub-module, q_round_sat: ACC_W input; outputs DATA_W result and sat flag. It is reused by other PE blocks.

Test Plan:
1. len=1, A=0x0100, B=0x0180 -> out_valid 2 cycles after the handshake; result=0x0180, sat_flag=0.
2. len=4, each pair A=0x0200, B=0x0300, in_valid low every other cycle -> result=0x1800, sat_flag=0; exactly 4 handshakes accepted, in_ready low after the 4th.
3. Rounding, three separate len=1 runs:
   - A=0x0001, B=0x0080 -> result=0x0001;
   - A=0x0001, B=0x007F -> result=0x0000;
   - A=0xFFFF, B=0x0080 -> result=0x0000.
4. Saturation:
   - len=2 of (0x7FFF, 0x7FFF) -> result=0x7FFF, sat_flag=1;
   - len=2 of (0x8000, 0x7FFF) -> result=0x8000, sat_flag=1;
   - len=2 of (0x4000, 0x0200) then (0xC000, 0x0200) -> result=0x0000, sat_flag=0 (no intermediate clamp).
5. out_ready low for 5 cycles in DONE with start pulsed -> result/sat_flag stable, start ignored; out_ready=1 -> IDLE next cycle.
6. Edge cases:
   - len=0 start -> out_valid next cycle, result=0;
   - rst asserted after 2 of 5 pairs -> next cycle all outputs at reset values;
   - a new len=1 run then gives the correct result with no residue.

Source files
------------

// File: rtl/pe_npu_pkg.sv
// Shared types and constants for the Q8.8 processing-element datapath.
// q8_8_t   : signed operand/result format (8 integer, 8 fractional bits)
// q16_16_t : signed full-precision product of two Q8.8 values
// seq_state_e : dot-product sequencer states
package pe_npu_pkg;

  typedef logic signed [15:0] q8_8_t;
  typedef logic signed [31:0] q16_16_t;

  localparam int unsigned Q_FRAC = 8;
  localparam q8_8_t       Q_MAX  = 16'sh7FFF;
  localparam q8_8_t       Q_MIN  = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Combinational round-half-up and saturate from a wide signed fixed-point
// accumulator (2*FRAC_W fractional bits) down to a DATA_W-bit value with
// FRAC_W fractional bits.
// Ports:
//   acc_i    : signed accumulator, ACC_W bits
//   result_o : rounded, clamped result, DATA_W bits
//   sat_o    : high when result_o was clamped to the max/min code
module q_round_sat
  import pe_npu_pkg::*;
#(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = Q_FRAC
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic        [DATA_W-1:0] result_o,
  output logic                     sat_o
);

  // One extra bit so adding the half-LSB bias can never wrap.
  localparam logic signed [ACC_W:0] Half =
    {{(ACC_W + 1 - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
  localparam logic signed [ACC_W:0] RMax =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] RMin =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] rounded;

  always_comb begin
    biased   = {acc_i[ACC_W-1], acc_i} + Half;
    rounded  = biased >>> FRAC_W;
    result_o = rounded[DATA_W-1:0];
    sat_o    = 1'b0;
    if (rounded > RMax) begin
      result_o = {1'b0, {(DATA_W - 1){1'b1}}};
      sat_o    = 1'b1;
    end else if (rounded < RMin) begin
      result_o = {1'b1, {(DATA_W - 1){1'b0}}};
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/pe_dot_seq.sv
// Q8.8 dot-product sequencer. Captures a vector length on start, streams
// operand pairs through a registered multiply into a full-precision
// accumulator, then rounds and saturates once to a single Q8.8 result.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i, len_i         : begin a dot product of len_i pairs (IDLE only)
//   busy_o                 : sequencer not idle
//   in_valid_i, in_ready_o : operand-pair handshake; a_i, b_i signed Q8.8
//   out_valid_o, out_ready_i : result handshake
//   result_o, sat_o        : rounded/saturated result and clamp flag
module pe_dot_seq
  import pe_npu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              sat_o
);

  localparam int unsigned ProdW = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W + LEN_W) begin : g_acc_w_check
    $error("pe_dot_seq: ACC_W too small for 2*DATA_W+LEN_W");
  end

  seq_state_e state_q, state_d;

  logic [LEN_W-1:0]        len_q, cnt_q, cnt_inc;
  logic signed [ProdW-1:0] prod_q, prod_d, a_ext, b_ext;
  logic                    prod_v_q;
  logic signed [ACC_W-1:0] acc_q, prod_ext;
  logic [DATA_W-1:0]       result_q, rs_result;
  logic                    sat_q, rs_sat;
  logic                    in_hs, start_hs;

  assign in_hs    = in_valid_i && (state_q == RUN);
  assign start_hs = start_i && (state_q == IDLE);
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign a_ext    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign prod_d   = a_ext * b_ext;
  assign prod_ext = {{(ACC_W - ProdW){prod_q[ProdW-1]}}, prod_q};

  q_round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc_i   (acc_q),
    .result_o(rs_result),
    .sat_o   (rs_sat)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. DRAIN holds while the last product is still pending,
  // then registers the rounded result on the way into DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (in_hs && (cnt_inc == len_q)) state_d = DRAIN;
      DRAIN:   if (!prod_v_q) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy_o      = (state_q != IDLE);
    in_ready_o  = (state_q == RUN);
    out_valid_o = (state_q == DONE);
    result_o    = result_q;
    sat_o       = sat_q;
  end

  // Datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else if (start_hs) begin
      len_q    <= len_i;
      cnt_q    <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      if (len_i == '0) begin
        result_q <= '0;
        sat_q    <= 1'b0;
      end
    end else begin
      if (in_hs) begin
        prod_q   <= prod_d;
        prod_v_q <= 1'b1;
        cnt_q    <= cnt_inc;
      end else begin
        prod_v_q <= 1'b0;
      end
      if (prod_v_q) acc_q <= acc_q + prod_ext;
      if ((state_q == DRAIN) && !prod_v_q) begin
        result_q <= rs_result;
        sat_q    <= rs_sat;
      end
    end
  end

endmodule

// File: tb/tb_pe_dot_seq.sv
// Directed bench for pe_dot_seq: hand-computed Q8.8 dot products covering
// latency, gaps in the input stream, rounding, saturation, output
// back-pressure, zero length and mid-run reset.
module tb_pe_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        sat_flag;

  int n_checks = 0;
  int n_fails  = 0;

  pe_dot_seq #(
    .DATA_W(16),
    .FRAC_W(8),
    .LEN_W (8),
    .ACC_W (40)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .busy_o     (busy),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a_in),
    .b_i        (b_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .sat_o      (sat_flag)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] er, input logic es);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_sat"}, 32'(sat_flag), 32'(es));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_fall"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_sat", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single pair, exact 2-cycle latency after the handshake edge.
    do_start(8'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send_pair("t1", 16'h0100, 16'h0180);
    check("t1_in_ready_drop", 32'(in_ready), 32'd0);
    check("t1_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat_e2", 32'(out_valid), 32'd1);
    get_result("t1", 16'h0180, 1'b0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: four pairs with a gap cycle after each; 4 * 6.0 = 24.0.
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      send_pair("t2", 16'h0200, 16'h0300);
      if (i < 3) begin
        tick();
        check("t2_gap_in_ready", 32'(in_ready), 32'd1);
      end
    end
    in_valid = 1'b1;
    check("t2_in_ready_after4", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    get_result("t2", 16'h1800, 1'b0);

    // 3: rounding at the half-LSB boundary.
    do_start(8'd1);
    send_pair("t3a", 16'h0001, 16'h0080);
    get_result("t3a", 16'h0001, 1'b0);
    do_start(8'd1);
    send_pair("t3b", 16'h0001, 16'h007F);
    get_result("t3b", 16'h0000, 1'b0);
    do_start(8'd1);
    send_pair("t3c", 16'hFFFF, 16'h0080);
    get_result("t3c", 16'h0000, 1'b0);

    // 4: saturation, and no clamping of intermediate sums.
    do_start(8'd2);
    send_pair("t4a", 16'h7FFF, 16'h7FFF);
    send_pair("t4a", 16'h7FFF, 16'h7FFF);
    get_result("t4a", 16'h7FFF, 1'b1);
    do_start(8'd2);
    send_pair("t4b", 16'h8000, 16'h7FFF);
    send_pair("t4b", 16'h8000, 16'h7FFF);
    get_result("t4b", 16'h8000, 1'b1);
    do_start(8'd2);
    send_pair("t4c", 16'h4000, 16'h0200);
    send_pair("t4c", 16'hC000, 16'h0200);
    get_result("t4c", 16'h0000, 1'b0);

    // 5: back-pressure in DONE with start pulsed; start on the handshake cycle.
    do_start(8'd1);
    send_pair("t5", 16'h0300, 16'h0200);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd3;
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_result", 32'(result), 32'h0600);
      check("t5_hold_sat", 32'(sat_flag), 32'd0);
      tick();
    end
    start     = 1'b0;
    check("t5_still_done", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t5_out_valid_fall", 32'(out_valid), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // 6a: zero length completes on the next edge with a zero result.
    do_start(8'd0);
    check("t6a_out_valid", 32'(out_valid), 32'd1);
    get_result("t6a", 16'h0000, 1'b0);

    // 6b: reset after 2 of 5 pairs.
    do_start(8'd5);
    send_pair("t6b", 16'h0400, 16'h0400);
    send_pair("t6b", 16'h0400, 16'h0400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_in_ready", 32'(in_ready), 32'd0);
    check("t6b_out_valid", 32'(out_valid), 32'd0);
    check("t6b_result", 32'(result), 32'd0);
    check("t6b_sat", 32'(sat_flag), 32'd0);

    // 6c: fresh run shows no residue from the aborted one.
    do_start(8'd1);
    send_pair("t6c", 16'h0100, 16'h0100);
    get_result("t6c", 16'h0100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
